synth_voice_allocator: RTL

//  Voice scheduler for the polyphonic synth. Takes note-on/note-off commands over a valid/ready port,

---
 rtl/synth_pkg.sv | 21 ++
 rtl/synth_voice_slot.sv | 44 ++++
 rtl/synth_voice_allocator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// Shared definitions for the synth command path: command opcodes,
// default widths and the voice allocator FSM states.
package synth_pkg;

    localparam int FCW_W = 24;
    localparam int KEY_W = 7;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_ON      = 2'b01,
        OP_OFF     = 2'b10,
        OP_ALL_OFF = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SCAN   = 2'b01,
        S_COMMIT = 2'b10
    } alloc_state_t;

endpackage

// File: rtl/synth_voice_slot.sv
// One carrier voice: frequency word, key tag, enable and saturating age.
// load takes priority over clear; age_tick only advances an enabled voice.
module synth_voice_slot #(
    parameter int KEY_W = 7,
    parameter int FCW_W = 24,
    parameter int AGE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear_en,
    input  logic             age_tick,
    input  logic [KEY_W-1:0] load_key,
    input  logic [FCW_W-1:0] load_fcw,
    output logic [FCW_W-1:0] fcw,
    output logic [KEY_W-1:0] key,
    output logic             en,
    output logic [AGE_W-1:0] age
);

    // Voice state registers: reset, load a new note, release, or age.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcw <= '0;
            key <= '0;
            en  <= 1'b0;
            age <= '0;
        end else if (load) begin
            fcw <= load_fcw;
            key <= load_key;
            en  <= 1'b1;
            age <= '0;
        end else begin
            if (clear_en) begin
                en <= 1'b0;
            end
            if (age_tick && en && (age != {AGE_W{1'b1}})) begin
                age <= age + AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/synth_voice_allocator.sv
// Voice scheduler: accepts note commands, scans the voices one per cycle,
// then commits a single update (retrigger > free voice > steal oldest).
module synth_voice_allocator #(
    parameter int N_VOICES = 4,
    parameter int KEY_W    = synth_pkg::KEY_W,
    parameter int FCW_W    = synth_pkg::FCW_W,
    parameter int AGE_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [KEY_W-1:0]          cmd_key,
    input  logic [FCW_W-1:0]          cmd_fcw,
    output logic [N_VOICES*FCW_W-1:0] carrier_fcws,
    output logic [N_VOICES-1:0]       note_en,
    output logic                      steal
);

    import synth_pkg::*;

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    alloc_state_t     state_q, state_d;
    logic             accept;

    cmd_op_t          op_q;
    logic [KEY_W-1:0] cmd_key_q;
    logic [FCW_W-1:0] cmd_fcw_q;
    logic [IDX_W-1:0] scan_idx;

    logic             match_found_q, match_found_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_found_q, free_found_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;
    logic [IDX_W-1:0] oldest_idx_q, oldest_idx_d;
    logic [AGE_W-1:0] oldest_age_q, oldest_age_d;

    logic [N_VOICES-1:0] slot_load, slot_clear, slot_tick;
    logic [IDX_W-1:0]    target;
    logic                steal_d;

    logic [FCW_W-1:0] slot_fcw [N_VOICES];
    logic [KEY_W-1:0] slot_key [N_VOICES];
    logic [AGE_W-1:0] slot_age [N_VOICES];

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    for (genvar i = 0; i < N_VOICES; i++) begin : g_slot
        synth_voice_slot #(
            .KEY_W (KEY_W),
            .FCW_W (FCW_W),
            .AGE_W (AGE_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (slot_load[i]),
            .clear_en (slot_clear[i]),
            .age_tick (slot_tick[i]),
            .load_key (cmd_key_q),
            .load_fcw (cmd_fcw_q),
            .fcw      (slot_fcw[i]),
            .key      (slot_key[i]),
            .en       (note_en[i]),
            .age      (slot_age[i])
        );
        assign carrier_fcws[i*FCW_W +: FCW_W] = slot_fcw[i];
    end

    // Scan comparators: fold the voice at scan_idx into the running results.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        match_found_d = (scan_idx == '0) ? 1'b0 : match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = (scan_idx == '0) ? 1'b0 : free_found_q;
        free_idx_d    = free_idx_q;
        oldest_idx_d  = oldest_idx_q;
        oldest_age_d  = oldest_age_q;
        if (!match_found_d && note_en[scan_idx] && (slot_key[scan_idx] == cmd_key_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = scan_idx;
        end
        if (!free_found_d && !note_en[scan_idx]) begin
            free_found_d = 1'b1;
            free_idx_d   = scan_idx;
        end
        // Strict compare keeps the lowest index on equal (or saturated) ages.
        if ((scan_idx == '0) || (slot_age[scan_idx] > oldest_age_q)) begin
            oldest_idx_d = scan_idx;
            oldest_age_d = slot_age[scan_idx];
        end
    end

    // Command capture at accept, and scan index / result registers during SCAN.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= OP_NOP;
            cmd_key_q     <= '0;
            cmd_fcw_q     <= '0;
            scan_idx      <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            oldest_age_q  <= '0;
        end else begin
            if (accept) begin
                op_q      <= cmd_op_t'(cmd_op);
                cmd_key_q <= cmd_key;
                cmd_fcw_q <= cmd_fcw;
                scan_idx  <= '0;
            end
            if (state_q == S_SCAN) begin
                scan_idx      <= scan_idx + IDX_W'(1);
                match_found_q <= match_found_d;
                match_idx_q   <= match_idx_d;
                free_found_q  <= free_found_d;
                free_idx_q    <= free_idx_d;
                oldest_idx_q  <= oldest_idx_d;
                oldest_age_q  <= oldest_age_d;
            end
        end
    end

    // FSM state and steal pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            steal   <= 1'b0;
        end else begin
            state_q <= state_d;
            steal   <= steal_d;
        end
    end

    // Next state and per-voice controls; outputs move only on COMMIT or ALL_OFF.
    always_comb begin
        state_d    = state_q;
        slot_load  = '0;
        slot_clear = '0;
        slot_tick  = '0;
        steal_d    = 1'b0;
        target     = oldest_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op_t'(cmd_op))
                        OP_ON, OP_OFF: state_d    = S_SCAN;
                        OP_ALL_OFF:    slot_clear = '1;
                        default:       ;
                    endcase
                end
            end
            S_SCAN: begin
                if (scan_idx == LAST_IDX) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                if (op_q == OP_ON) begin
                    if (match_found_q) begin
                        target = match_idx_q;
                    end else if (free_found_q) begin
                        target = free_idx_q;
                    end else begin
                        steal_d = 1'b1;
                    end
                    slot_load[target] = 1'b1;
                    slot_tick         = ~slot_load;
                end else if ((op_q == OP_OFF) && match_found_q) begin
                    slot_clear[match_idx_q] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
